// File: rtl/gen2_pkg.sv
// Shared command codes, state/reply encodings and helpers for the Gen2 tag controller.
package gen2_pkg;

    localparam logic [2:0] CmdQuery    = 3'd0;
    localparam logic [2:0] CmdQueryRep = 3'd1;
    localparam logic [2:0] CmdQueryAdj = 3'd2;
    localparam logic [2:0] CmdAck      = 3'd3;
    localparam logic [2:0] CmdNak      = 3'd4;
    localparam logic [2:0] CmdReqRn    = 3'd5;
    localparam logic [2:0] CmdSelect   = 3'd6;

    localparam logic [1:0] UpdnInc    = 2'b11;
    localparam logic [1:0] UpdnDec    = 2'b01;
    localparam logic [1:0] UpdnIgnore = 2'b10;

    typedef enum logic [2:0] {
        StReady        = 3'd0,
        StArbitrate    = 3'd1,
        StReply        = 3'd2,
        StAcknowledged = 3'd3,
        StOpen         = 3'd4
    } tag_state_e;

    typedef enum logic [1:0] {
        TxRn16   = 2'd0,
        TxEpc    = 2'd1,
        TxHandle = 2'd2
    } tx_type_e;

    function automatic logic [15:0] draw_mask(input logic [3:0] q);
        return (16'd1 << q) - 16'd1;
    endfunction

    function automatic logic [3:0] q_adjust(input logic [3:0] q, input logic [1:0] updn);
        logic [3:0] r;
        r = q;
        if (updn == UpdnInc && q != 4'd15) begin
            r = q + 4'd1;
        end else if (updn == UpdnDec && q != 4'd0) begin
            r = q - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gen2_slot_cnt.sv
// Q register and slot counter: masked load from the RNG, decrement, set-to-max and
// saturating Q adjust.
module gen2_slot_cnt
    import gen2_pkg::*;
#(
    parameter int unsigned SLOT_W = 15
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              q_load,
    input  logic [3:0]        q_val,
    input  logic              q_adj,
    input  logic [1:0]        updn,
    input  logic              draw,
    input  logic [15:0]       rng_value,
    input  logic              dec,
    input  logic              set_max,
    output logic [SLOT_W-1:0] slot,
    output logic              draw_zero,
    output logic              dec_zero
);

    logic [3:0]        q_q, q_d;
    logic [SLOT_W-1:0] slot_q, slot_d, draw_slot;

    always_comb begin
        q_d = q_q;
        if (q_load) begin
            q_d = q_val;
        end else if (q_adj) begin
            q_d = q_adjust(q_q, updn);
        end
        // The draw sees the Q value being written in the same cycle.
        draw_slot = SLOT_W'(rng_value & draw_mask(q_d));
        draw_zero = (draw_slot == '0);
        dec_zero  = (slot_q == SLOT_W'(1));

        slot_d = slot_q;
        if (draw) begin
            slot_d = draw_slot;
        end else if (dec) begin
            slot_d = slot_q - SLOT_W'(1);
        end else if (set_max) begin
            slot_d = '1;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= 4'd0;
            slot_q <= '0;
        end else begin
            q_q    <= q_d;
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/gen2_inv_ctrl.sv
// EPC Gen2 tag inventory/access controller: tag state, RN16/handle and reply scheduling.
// Optional reply timeout enabled by defining GEN2_T2_TIMEOUT_EN.
module gen2_inv_ctrl
    import gen2_pkg::*;
#(
    parameter int unsigned T2_CYCLES = 25000,
    parameter int unsigned SLOT_W    = 15
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_code,
    input  logic [3:0]        cmd_q,
    input  logic [1:0]        cmd_updn,
    input  logic [15:0]       cmd_rn16,
    input  logic [15:0]       rng_value,
    output logic              rng_next,
    output logic              tx_req,
    output logic [1:0]        tx_type,
    output logic [15:0]       tx_rn16,
    input  logic              tx_done,
    output logic [2:0]        tag_state,
    output logic [SLOT_W-1:0] slot_cnt
);

    tag_state_e  state_q, state_d;
    tx_type_e    tx_type_q, tx_type_d;
    logic [15:0] rn16_q, rn16_d, handle_q, handle_d, tx_rn16_q, tx_rn16_d;
    logic        tx_req_q, tx_req_d, rng_next_q, rng_next_d;

    logic accept, rn_match, h_match, in_arb, in_reply, in_ack, in_open;
    logic is_query, is_rep, is_adj, is_ack, is_nak, is_reqrn;
    logic q_load, q_adj, draw, dec, set_max, draw_zero, dec_zero;
    logic redraw, send_rn16, t2_fire;

    // Commands are dropped while a reply is outstanding.
    assign accept   = cmd_valid && !tx_req_q;
    assign is_query = accept && (cmd_code == CmdQuery);
    assign is_rep   = accept && (cmd_code == CmdQueryRep);
    assign is_adj   = accept && (cmd_code == CmdQueryAdj);
    assign is_ack   = accept && (cmd_code == CmdAck);
    assign is_nak   = accept && (cmd_code == CmdNak);
    assign is_reqrn = accept && (cmd_code == CmdReqRn);
    assign rn_match = (cmd_rn16 == rn16_q);
    assign h_match  = (cmd_rn16 == handle_q);
    assign in_arb   = (state_q == StArbitrate);
    assign in_reply = (state_q == StReply);
    assign in_ack   = (state_q == StAcknowledged);
    assign in_open  = (state_q == StOpen);

    assign q_load  = is_query;
    assign q_adj   = is_adj && in_arb && (cmd_updn != UpdnIgnore);
    assign draw    = q_load || q_adj;
    assign dec     = is_rep && in_arb;
    // Every non-Query entry into ARBITRATE parks the slot at max so QueryRep never wraps.
    assign set_max = (in_reply && ((is_ack && !rn_match) || is_nak || is_rep || is_adj)) ||
                     (in_ack && (is_nak || ((is_ack || is_reqrn) && !rn_match))) ||
                     (in_open && is_nak) || t2_fire;

    gen2_slot_cnt #(
        .SLOT_W (SLOT_W)
    ) u_slot_cnt (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .q_load    (q_load),
        .q_val     (cmd_q),
        .q_adj     (q_adj),
        .updn      (cmd_updn),
        .draw      (draw),
        .rng_value (rng_value),
        .dec       (dec),
        .set_max   (set_max),
        .slot      (slot_cnt),
        .draw_zero (draw_zero),
        .dec_zero  (dec_zero)
    );

    always_comb begin
        state_d    = state_q;
        rn16_d     = rn16_q;
        handle_d   = handle_q;
        tx_req_d   = tx_req_q;
        tx_type_d  = tx_type_q;
        tx_rn16_d  = tx_rn16_q;
        rng_next_d = 1'b0;
        redraw     = 1'b0;
        send_rn16  = 1'b0;

        if (tx_req_q && tx_done) begin
            tx_req_d = 1'b0;
        end

        if (accept) begin
            case (cmd_code)
                CmdSelect: state_d = StReady;
                CmdQuery: begin
                    state_d   = draw_zero ? StReply : StArbitrate;
                    send_rn16 = draw_zero;
                end
                CmdQueryRep, CmdQueryAdj: begin
                    case (state_q)
                        StArbitrate: begin
                            if (dec && dec_zero) begin
                                state_d   = StReply;
                                redraw    = 1'b1;
                                send_rn16 = 1'b1;
                            end else if (q_adj && draw_zero) begin
                                state_d   = StReply;
                                send_rn16 = 1'b1;
                            end
                        end
                        StReply:                state_d = StArbitrate;
                        StAcknowledged, StOpen: state_d = StReady;
                        default: ;
                    endcase
                end
                CmdAck: begin
                    if (in_reply || in_ack) begin
                        if (rn_match) begin
                            state_d   = StAcknowledged;
                            tx_req_d  = 1'b1;
                            tx_type_d = TxEpc;
                        end else begin
                            state_d = StArbitrate;
                        end
                    end
                end
                CmdNak: begin
                    if (in_reply || in_ack || in_open) begin
                        state_d = StArbitrate;
                    end
                end
                CmdReqRn: begin
                    if (in_ack) begin
                        if (rn_match) begin
                            state_d    = StOpen;
                            handle_d   = rng_value;
                            rng_next_d = 1'b1;
                            tx_req_d   = 1'b1;
                            tx_type_d  = TxHandle;
                            tx_rn16_d  = rng_value;
                        end else begin
                            state_d = StArbitrate;
                        end
                    end else if (in_open && h_match) begin
                        redraw    = 1'b1;
                        send_rn16 = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (draw || redraw) begin
            rn16_d     = rng_value;
            rng_next_d = 1'b1;
        end
        if (send_rn16) begin
            tx_req_d  = 1'b1;
            tx_type_d = TxRn16;
            tx_rn16_d = rng_value;
        end
        if (t2_fire) begin
            state_d = StArbitrate;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StReady;
            rn16_q     <= 16'd0;
            handle_q   <= 16'd0;
            tx_req_q   <= 1'b0;
            tx_type_q  <= TxRn16;
            tx_rn16_q  <= 16'd0;
            rng_next_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rn16_q     <= rn16_d;
            handle_q   <= handle_d;
            tx_req_q   <= tx_req_d;
            tx_type_q  <= tx_type_d;
            tx_rn16_q  <= tx_rn16_d;
            rng_next_q <= rng_next_d;
        end
    end

`ifdef GEN2_T2_TIMEOUT_EN
    localparam logic [15:0] T2Limit = 16'(T2_CYCLES - 1);

    logic [15:0] t2_cnt_q;
    logic        t2_run_q, t2_start;

    assign t2_start = tx_req_q && tx_done && (in_reply || in_ack);
    assign t2_fire  = t2_run_q && !cmd_valid && (t2_cnt_q == T2Limit) && (in_reply || in_ack);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            t2_run_q <= 1'b0;
            t2_cnt_q <= 16'd0;
        end else if (cmd_valid || t2_fire) begin
            t2_run_q <= 1'b0;
        end else if (t2_start) begin
            t2_run_q <= 1'b1;
            t2_cnt_q <= 16'd0;
        end else if (t2_run_q) begin
            t2_cnt_q <= t2_cnt_q + 16'd1;
        end
    end
`else
    logic unused_t2;
    assign unused_t2 = ^T2_CYCLES;
    assign t2_fire   = 1'b0;
`endif

    assign rng_next  = rng_next_q;
    assign tx_req    = tx_req_q;
    assign tx_type   = tx_type_q;
    assign tx_rn16   = tx_rn16_q;
    assign tag_state = state_q;

endmodule

// File: doc/gen2_inv_ctrl.md
Name: gen2_inv_ctrl

Overview:
- ISO 18000-6C (EPC Gen2) tag inventory/access controller for the 512-bit tag.
- Sits between the forward-link command decoder (fed by rd_data) and the backscatter encoder (driving tag_data).
- Tracks the tag state, Q and slot counter, and RN16/handle, and decides which reply the encoder sends.
- Schedules the encoder: one reply at a time, under a req/done handshake.

Parameters:
- T2_CYCLES, 25000, reply timeout in clk_50m cycles (20 Tpri at 25 us Tpri); used only with the optional feature.
- SLOT_W, 15, slot counter width.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  one-cycle strobe: decoded command with correct CRC.
- cmd_code  in  3  command code (package constants).
- cmd_q  in  4  Q field of Query.
- cmd_updn  in  2  UpDn field of QueryAdjust.
- cmd_rn16  in  16  RN16/handle carried by ACK/Req_RN.
- rng_value  in  16  current LFSR value.
- rng_next  out  1  pulse: LFSR value consumed, advance.
- tx_req  out  1  reply request to the encoder.
- tx_type  out  2  RN16 / EPC / HANDLE.
- tx_rn16  out  16  RN16 or handle to backscatter.
- tx_done  in  1  one-cycle pulse: encoder finished.
- tag_state  out  3  current state.
- slot_cnt  out  SLOT_W  current slot counter.

Behaviour:
- Reset values: state READY, Q=0, slot=0, rn16=0, handle=0, tx_req=0, tx_type=RN16, tx_rn16=0, rng_next=0.
- Latency: commands take effect in the cycle after cmd_valid; tx_req rises in that same cycle; rng_next pulses in the cycle the RNG is sampled.
- tx_req holds high until tx_done, then falls the next cycle.
- Every cmd_valid while tx_req=1 is ignored. tx_done when tx_req=0 is ignored.
- Draw operation: slot = rng_value & ((1<<Q)-1); rn16 = rng_value; pulse rng_next. Q=0 gives slot 0.
- Select, any state: go to READY.
- Query, any state: Q=cmd_q, draw. slot==0 goes to REPLY and sends RN16; otherwise go to ARBITRATE.
- ARBITRATE:
  - QueryRep: slot=slot-1; if the result is 0, go to REPLY and send RN16 with a fresh RN16 draw.
  - QueryAdjust: cmd_updn 11 gives Q+1, saturating at 15; 01 gives Q-1, saturating at 0; 00 leaves Q unchanged; 10 ignores the command. Then draw; slot 0 goes to REPLY.
- REPLY:
  - ACK with cmd_rn16==rn16: go to ACKNOWLEDGED, send EPC.
  - ACK mismatch, NAK, QueryRep or QueryAdjust: go to ARBITRATE with slot = all ones (no wrap-to-zero reply).
- ACKNOWLEDGED:
  - ACK match: resend EPC.
  - Req_RN match: handle=rng_value, pulse rng_next, go to OPEN, send HANDLE.
  - QueryRep or QueryAdjust: go to READY.
  - NAK, or mismatched ACK/Req_RN: go to ARBITRATE.
- OPEN:
  - Req_RN with cmd_rn16==handle: send RN16 with a fresh draw (handle unchanged).
  - Mismatch: ignored.
  - NAK: go to ARBITRATE.
  - QueryRep or QueryAdjust: go to READY.
- Unlisted command/state pairs leave state and registers unchanged.
- The slot counter never underflows: QueryRep in ARBITRATE always has slot≥1 (slot 0 leaves ARBITRATE).
- Reset mid-reply drops tx_req immediately (asynchronously).

Optional Feature:
- Macro GEN2_T2_TIMEOUT_EN.
- Defined: a 16-bit timer starts on tx_done in REPLY or ACKNOWLEDGED. If no cmd_valid arrives within T2_CYCLES cycles, go to ARBITRATE with slot = all ones. Any cmd_valid clears the timer.
- Undefined: no timer; the tag waits indefinitely.

Decomposition:
- Package gen2_pkg:
  - Command codes: QUERY=0, QUERYREP=1, QUERYADJ=2, ACK=3, NAK=4, REQRN=5, SELECT=6.
  - States: READY=0, ARBITRATE=1, REPLY=2, ACKNOWLEDGED=3, OPEN=4.
  - tx types: RN16=0, EPC=1, HANDLE=2.
- One sub-module: gen2_slot_cnt, holding Q and slot (load-masked, decrement, set-max, Q adjust saturation).

Test Plan:
- Reset, rng_value=16'h1234, Query Q=0 -> REPLY, tx_req=1, tx_type=RN16, tx_rn16=16'h1234, rng_next one pulse.
- Query Q=2 with rng_value=16'h0003 -> ARBITRATE, slot=3; three QueryReps -> slot 2,1,0; third enters REPLY with RN16 request.
- In REPLY (rn16=16'hABCD): ACK 16'hABCD -> ACKNOWLEDGED, EPC request; Req_RN 16'hABCD with rng_value=16'h5555 -> OPEN, tx_type=HANDLE, tx_rn16=16'h5555.
- In REPLY: ACK 16'h0000 -> ARBITRATE, slot=15'h7FFF. Q=15, QueryAdjust up -> Q stays 15. Q=0, QueryAdjust down -> Q stays 0.
- Commands issued while tx_req=1 (before tx_done) -> no state change; Select in OPEN -> READY.
- With GEN2_T2_TIMEOUT_EN and T2_CYCLES=100: REPLY, tx_done, 100 idle cycles -> ARBITRATE. Repeat with ACK at cycle 50 -> ACKNOWLEDGED.
